// File: rtl/therm_pkg.sv
// -----------------------------------------------------------------------------
// therm_pkg
// Shared constants for the sign-plus-thermometer encoder.
//   IN_W_DEF    : default width of the signed pre-activation sum
//   CODE_W_DEF  : default width of the sign + thermometer code
//   MAG_MAX_DEF : default largest representable magnitude (CODE_W_DEF - 1)
//   NEG_ZERO    : the sign-only code that must never reach the outputs
//   POS_FULL    : code for +MAG_MAX (also the positive clamp result)
//   NEG_FULL    : code for -MAG_MAX (also the negative clamp result)
// -----------------------------------------------------------------------------
package therm_pkg;

    localparam int IN_W_DEF    = 8;
    localparam int CODE_W_DEF  = 17;
    localparam int MAG_MAX_DEF = CODE_W_DEF - 1;

    localparam logic [CODE_W_DEF-1:0] NEG_ZERO = 17'h1_0000;
    localparam logic [CODE_W_DEF-1:0] POS_FULL = 17'h0_FFFF;
    localparam logic [CODE_W_DEF-1:0] NEG_FULL = 17'h1_FFFF;

    // Bits needed to hold a magnitude in 0..mag_max.
    function automatic int mag_width(input int mag_max);
        return $clog2(mag_max + 1);
    endfunction

endpackage

// File: rtl/therm_expand.sv
// -----------------------------------------------------------------------------
// therm_expand
// Purely combinational magnitude-to-thermometer expansion.
//   sign : 1 = negative
//   mag  : magnitude, 0..CODE_W-1
//   code : bit CODE_W-1 = sign, low bits = mag ones from bit 0 upwards
// A zero magnitude always yields a cleared sign bit, so the negative-zero
// code cannot be produced even if an upstream stage presents sign=1, mag=0.
// -----------------------------------------------------------------------------
module therm_expand #(
    parameter int CODE_W = 17,
    parameter int MAG_W  = 5
) (
    input  logic              sign,
    input  logic [MAG_W-1:0]  mag,
    output logic [CODE_W-1:0] code
);

    genvar gi;
    generate
        for (gi = 0; gi < CODE_W - 1; gi++) begin : g_therm
            // Bit gi is set when the magnitude covers position gi.
            assign code[gi] = (32'(mag) > gi);
        end
    endgenerate

    assign code[CODE_W-1] = sign && (mag != '0);

endmodule

// File: rtl/therm_encoder.sv
// -----------------------------------------------------------------------------
// therm_encoder
// Clamps a signed pre-activation sum to [-MAG_MAX, +MAG_MAX] and emits it as a
// sign + thermometer code through a two-stage valid/ready pipeline.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_sum is the signed sample
//   out_valid/out_ready : output handshake carrying out_code and out_sat
//   out_code            : bit CODE_W-1 = sign, low bits = thermometer magnitude
//   out_sat             : the sample was clamped
//   sat_clr             : synchronous clear of sat_cnt (wins over increment)
//   sat_cnt             : saturating count of clamped samples accepted
// Stage 1 holds sign, magnitude and the clamp flag; stage 2 holds the expanded
// code and drives the outputs. Accepted in cycle N -> visible in cycle N+2.
// -----------------------------------------------------------------------------
module therm_encoder
    import therm_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int CODE_W  = CODE_W_DEF,
    parameter int MAG_MAX = MAG_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_code,
    output logic                   out_sat,
    input  logic                   sat_clr,
    output logic [7:0]             sat_cnt
);

    localparam int MAG_W = mag_width(MAG_MAX);

    // Clamp stage (combinational, in front of S1)
    logic signed [31:0] sum_ext;
    logic               clamp_sign;
    logic [MAG_W-1:0]   clamp_mag;
    logic               clamp_sat;

    always_comb begin
        sum_ext    = 32'(in_sum);
        clamp_sign = 1'b0;
        clamp_mag  = '0;
        clamp_sat  = 1'b0;
        if (sum_ext > MAG_MAX) begin
            clamp_mag = MAG_W'(MAG_MAX);
            clamp_sat = 1'b1;
        end else if (sum_ext < -MAG_MAX) begin
            clamp_sign = 1'b1;
            clamp_mag  = MAG_W'(MAG_MAX);
            clamp_sat  = 1'b1;
        end else if (sum_ext < 0) begin
            clamp_sign = 1'b1;
            clamp_mag  = MAG_W'(-sum_ext);
        end else begin
            clamp_mag = MAG_W'(sum_ext);
        end
    end

    // Pipeline state
    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic [MAG_W-1:0]  s1_mag_reg;
    logic              s1_sat_reg;
    logic              s2_valid_reg;
    logic [CODE_W-1:0] s2_code_reg;
    logic              s2_sat_reg;
    logic [7:0]        sat_cnt_reg;

    logic [CODE_W-1:0] exp_code;
    logic              s2_advance;
    logic              in_accept;

    therm_expand #(
        .CODE_W (CODE_W),
        .MAG_W  (MAG_W)
    ) u_expand (
        .sign (s1_sign_reg),
        .mag  (s1_mag_reg),
        .code (exp_code)
    );

    // S2 can take a new value when empty or being drained this cycle; S1 can
    // then advance, which frees it for a new input. No path from in_valid.
    assign s2_advance = !s2_valid_reg || out_ready;
    assign in_ready   = !s1_valid_reg || s2_advance;
    assign in_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s1_sat_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_code_reg  <= '0;
            s2_sat_reg   <= 1'b0;
            sat_cnt_reg  <= 8'd0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_sign_reg <= clamp_sign;
                    s1_mag_reg  <= clamp_mag;
                    s1_sat_reg  <= clamp_sat;
                end
            end

            // Payload only reloads with a real sample so a stalled output
            // stays frozen and an emptied stage keeps harmless old data.
            if (s2_advance) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_code_reg <= exp_code;
                    s2_sat_reg  <= s1_sat_reg;
                end
            end

            if (sat_clr) begin
                sat_cnt_reg <= 8'd0;
            end else if (in_accept && clamp_sat && (sat_cnt_reg != 8'hFF)) begin
                sat_cnt_reg <= sat_cnt_reg + 8'd1;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_code  = s2_code_reg;
    assign out_sat   = s2_sat_reg;
    assign sat_cnt   = sat_cnt_reg;

endmodule

// File: tb/tb_therm_encoder.sv
// -----------------------------------------------------------------------------
// tb_therm_encoder
// Self-checking bench for therm_encoder with default parameters. A negedge
// monitor keeps a queue of expected outputs computed arithmetically from each
// accepted in_sum, plus a saturating clamp counter, and checks ordering,
// latency, stall stability and in_ready against queue occupancy.
// -----------------------------------------------------------------------------
module tb_therm_encoder;
    import therm_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [7:0]  in_sum = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [16:0]        out_code;
    logic               out_sat;
    logic               sat_clr = 1'b0;
    logic [7:0]         sat_cnt;

    therm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_sat   (out_sat),
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    int applied     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        applied++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: clamp with plain integer arithmetic, then build the
    // thermometer as 2^|v|-1 and put the sign on top for negative values.
    typedef struct packed {
        logic [16:0] code;
        logic        sat;
    } exp_t;

    function automatic exp_t ref_model(input int s);
        exp_t e;
        int   v;
        int   m;
        v     = s;
        e.sat = 1'b0;
        if (v > 16) begin
            v = 16;
            e.sat = 1'b1;
        end else if (v < -16) begin
            v = -16;
            e.sat = 1'b1;
        end
        m      = (v < 0) ? -v : v;
        e.code = 17'((1 << m) - 1);
        if (v < 0) e.code[16] = 1'b1;
        return e;
    endfunction

    typedef struct {
        exp_t e;
        int   cyc;
    } flight_t;

    flight_t     q[$];
    flight_t     f;
    int          cyc = 0;
    int          pops = 0;
    int          model_cnt = 0;
    bit          mon_on = 1'b0;
    bit          lat_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [16:0] prev_code;
    logic        prev_sat;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            if (!rst_n) begin
                q.delete();
                model_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_code", int'(out_code), int'(prev_code));
                    check("stall_sat", int'(out_sat), int'(prev_sat));
                end
                check("in_ready", int'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
                check("sat_cnt", int'(sat_cnt), model_cnt);
                if (out_valid) check("neg_zero", (out_code == NEG_ZERO) ? 1 : 0, 0);
                if (out_valid && out_ready) begin
                    check("out_pending", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        f = q.pop_front();
                        check("out_code", int'(out_code), int'(f.e.code));
                        check("out_sat", int'(out_sat), int'(f.e.sat));
                        if (lat_mode) check("latency", cyc - f.cyc, 2);
                    end
                    pops++;
                    $display("out %0d: code=%05h sat=%0b cyc=%0d", pops, out_code, out_sat, cyc);
                end
                if (in_valid && in_ready) begin
                    f.e   = ref_model(int'(in_sum));
                    f.cyc = cyc;
                    q.push_back(f);
                end
                if (sat_clr) model_cnt = 0;
                else if (in_valid && in_ready && ref_model(int'(in_sum)).sat && model_cnt < 255)
                    model_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_code  = out_code;
                prev_sat   = out_sat;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          sum;
        logic [16:0] code;
        logic        sat;
    } vec_t;

    vec_t        tbl[12];
    logic [3:0]  pat;
    int          sent;
    int          c;
    int          pops_base;
    bit          found;

    initial begin
        tbl[0]  = '{0,    17'h0_0000, 1'b0};
        tbl[1]  = '{-1,   17'h1_0001, 1'b0};
        tbl[2]  = '{127,  17'h0_FFFF, 1'b1};
        tbl[3]  = '{-128, 17'h1_FFFF, 1'b1};
        tbl[4]  = '{3,    17'h0_0007, 1'b0};
        tbl[5]  = '{-3,   17'h1_0007, 1'b0};
        tbl[6]  = '{16,   17'h0_FFFF, 1'b0};
        tbl[7]  = '{-16,  17'h1_FFFF, 1'b0};
        tbl[8]  = '{17,   17'h0_FFFF, 1'b1};
        tbl[9]  = '{-17,  17'h1_FFFF, 1'b1};
        tbl[10] = '{1,    17'h0_0001, 1'b0};
        tbl[11] = '{5,    17'h0_001F, 1'b0};

        // Reset state
        repeat (3) tick();
        mon_on = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_code", int'(out_code), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_sat_cnt", int'(sat_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);

        // Directed table, one sample at a time
        out_ready = 1'b1;
        lat_mode  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_sum   = 8'(tbl[i].sum);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            found    = 1'b0;
            for (int k = 0; k < 6; k++) begin
                if (out_valid) begin
                    check("tbl_code", int'(out_code), int'(tbl[i].code));
                    check("tbl_sat", int'(out_sat), int'(tbl[i].sat));
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check("tbl_seen", int'(found), 1);
            tick();
        end

        // Back-to-back sweep -20..+20 with out_ready high
        for (int s = -20; s <= 20; s++) begin
            in_sum   = 8'(s);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Ten samples with out_ready cycling 1,0,0,1
        lat_mode  = 1'b0;
        pat       = 4'b1001;
        sent      = 0;
        c         = 0;
        pops_base = pops;
        while (sent < 10 && c < 200) begin
            out_ready = pat[c % 4];
            in_valid  = 1'b1;
            in_sum    = 8'(sent * 5 - 22);
            #1;
            if (in_ready) sent++;
            tick();
            c++;
        end
        in_valid = 1'b0;
        while (q.size() > 0 && c < 300) begin
            out_ready = pat[c % 4];
            tick();
            c++;
        end
        out_ready = 1'b1;
        tick();
        check("stream_count", pops - pops_base, 10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_sum    = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 40) == 0);
            tick();
        end
        in_valid  = 1'b0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        // Saturating clamp counter and clear priority
        lat_mode = 1'b1;
        sat_clr  = 1'b1;
        tick();
        sat_clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_sum   = 8'(100);
            tick();
        end
        in_valid = 1'b0;
        check("sat_cnt_max", int'(sat_cnt), 255);
        in_valid = 1'b1;
        in_sum   = -8'sd100;
        sat_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        check("sat_clr_prio", int'(sat_cnt), 0);
        repeat (4) tick();

        // Fill both stages under stall, then reset mid-flight
        lat_mode  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = -8'sd50;
        for (int k = 0; k < 10; k++) begin
            if (!in_ready) break;
            tick();
        end
        check("fill_stall", int'(in_ready), 0);
        check("fill_sat_cnt", int'(sat_cnt), 2);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_sat_cnt", int'(sat_cnt), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        pops_base = pops;
        repeat (6) tick();
        check("midrst_no_stale", pops - pops_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
